// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a combinational instruction memory: PC register, single-entry
// {pc, instr} output buffer with valid/ready, redirect handling and sticky fetch faults.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_BOOT  | one cycle after reset, no capture, redirects ignored
// S_RUN   | sequential fetch into the output buffer
// S_FAULT | bad pc or bad redirect target seen; pc frozen until good redirect
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 20
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_RANGE = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        pc_ok, tgt_ok, tgt_misaligned;
  logic        redir, capture, handshake;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < IMEM_WORDS);
  endfunction

  assign pc_ok          = addr_ok(pc);
  assign tgt_ok         = addr_ok(redirect_pc);
  assign tgt_misaligned = (redirect_pc[1:0] != 2'b00);
  assign handshake      = out_valid && out_ready;
  assign redir          = redirect_valid && (state != S_BOOT);
  // A full buffer that decode is not taking stalls fetch, including the fault check.
  assign capture        = (state == S_RUN) && !redir && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN: begin
        if (redir) begin
          state_nxt = tgt_ok ? S_RUN : S_FAULT;
        end else if (capture && !pc_ok) begin
          state_nxt = S_FAULT;
        end
      end
      S_FAULT: begin
        if (redir && tgt_ok) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    fault     = 1'b0;
    imem_addr = pc;
    if (state == S_FAULT) begin
      fault = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= 32'd0;
      out_pc      <= 32'd0;
      fault_cause <= CAUSE_NONE;
      fault_pc    <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      if (handshake) begin
        instr_count <= instr_count + 32'd1;
      end
      // Redirect flushes the buffer after any same-cycle handshake has been counted.
      if (redir) begin
        out_valid <= 1'b0;
        if (tgt_ok) begin
          pc          <= redirect_pc;
          fault_cause <= CAUSE_NONE;
        end else begin
          fault_cause <= tgt_misaligned ? CAUSE_ALIGN : CAUSE_RANGE;
          fault_pc    <= redirect_pc;
        end
      end else if (capture) begin
        if (pc_ok) begin
          out_instr <= imem_data;
          out_pc    <= pc;
          out_valid <= 1'b1;
          pc        <= pc + 32'd4;
        end else begin
          out_valid   <= 1'b0;
          fault_cause <= CAUSE_RANGE;
          fault_pc    <= pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: expected {pc, instr} pairs are queued as stimulus is driven
// and popped by a monitor on every accepted handshake.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_pc = 32'hFFFF_FFFF;

  imem_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(20)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .fault(fault), .fault_cause(fault_cause), .fault_pc(fault_pc), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] < 30'd20) return 32'hA500_0000 + {2'b00, a[31:2]} * 32'h0001_0011;
    return 32'hDEADBEEF;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  // Handshakes complete at the next rising edge; inputs are already stable at negedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL emit: unexpected out_pc=%h out_instr=%h, nothing expected", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          errors++;
          $display("FAIL emit: got pc=%h instr=%h, expected pc=%h instr=%h",
                   out_pc, out_instr, e[63:32], e[31:0]);
        end
        last_pc = out_pc;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    checks++;
    if ({out_valid, out_pc, out_instr, fault, fault_cause, fault_pc, instr_count, imem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b pc=%h instr=%h f=%b c=%b fpc=%h cnt=%0d addr=%h, all zero expected",
               out_valid, out_pc, out_instr, fault, fault_cause, fault_pc, instr_count, imem_addr);
    end
  endtask

  task automatic test_sequential();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL boot_no_capture: out_valid=%b expected 0", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== mem_word(32'(i * 4))) begin
        errors++;
        $display("FAIL seq_out: v=%b pc=%h instr=%h expected pc=%h instr=%h",
                 out_valid, out_pc, out_instr, 32'(i * 4), mem_word(32'(i * 4)));
      end
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (instr_count !== 32'd4) begin
      errors++; $display("FAIL seq_count: instr_count=%0d expected 4", instr_count);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== mem_word(32'h10) ||
          imem_addr !== 32'h14 || instr_count !== 32'd4) begin
        errors++;
        $display("FAIL stall_hold: v=%b pc=%h instr=%h addr=%h cnt=%0d expected 1/10/%h/14/4",
                 out_valid, out_pc, out_instr, imem_addr, instr_count, mem_word(32'h10));
      end
    end
    push_exp(32'h10); push_exp(32'h14);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h14 || instr_count !== 32'd5) begin
      errors++;
      $display("FAIL stall_resume: v=%b pc=%h cnt=%0d expected 1/14/5", out_valid, out_pc, instr_count);
    end
  endtask

  task automatic test_redirect_handshake();
    rst = 1'b1; tick(); rst = 1'b0;
    exp_q.delete();
    push_exp(32'h0); push_exp(32'h4);
    out_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || instr_count !== 32'd1) begin
      errors++;
      $display("FAIL redir_setup: v=%b pc=%h cnt=%0d expected 1/4/1", out_valid, out_pc, instr_count);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    push_exp(32'h10);
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h10 || instr_count !== 32'd2) begin
      errors++;
      $display("FAIL redir_flush: v=%b addr=%h cnt=%0d expected 0/10/2", out_valid, imem_addr, instr_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== mem_word(32'h10)) begin
      errors++;
      $display("FAIL redir_target: v=%b pc=%h instr=%h expected 1/10/%h",
               out_valid, out_pc, out_instr, mem_word(32'h10));
    end
  endtask

  task automatic test_bounds();
    int n = 0;
    for (int w = 5; w < 20; w++) push_exp(32'(w * 4));
    while (!fault && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'b01 || fault_pc !== 32'h50 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bounds_fault: f=%b c=%b fpc=%h v=%b after %0d cycles, expected 1/01/50/0",
               fault, fault_cause, fault_pc, out_valid, n);
    end
    checks++;
    if (instr_count !== 32'd18 || last_pc !== 32'h4C || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounds_last: cnt=%0d last_pc=%h pending=%0d expected 18/4c/0",
               instr_count, last_pc, exp_q.size());
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 32'h50 || instr_count !== 32'd18) begin
      errors++;
      $display("FAIL fault_hold: v=%b f=%b addr=%h cnt=%0d expected 0/1/50/18",
               out_valid, fault, imem_addr, instr_count);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    push_exp(32'h0);
    checks++;
    if (fault !== 1'b0 || fault_cause !== 2'b00 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL fault_clear: f=%b c=%b addr=%h expected 0/00/0", fault, fault_cause, imem_addr);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem_word(32'h0)) begin
      errors++;
      $display("FAIL refetch: v=%b pc=%h instr=%h expected 1/0/%h", out_valid, out_pc, out_instr, mem_word(32'h0));
    end
  endtask

  task automatic test_bad_redirect();
    logic [31:0] tgt[4]  = '{32'h50, 32'h6, 32'h1000, 32'h4C};
    logic [1:0]  cause[4] = '{2'b01, 2'b10, 2'b01, 2'b00};
    logic [31:0] fpc[4]  = '{32'h50, 32'h6, 32'h1000, 32'h1000};
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      redirect_valid = 1'b1; redirect_pc = tgt[i];
      tick();
      checks++;
      if (fault !== (cause[i] != 2'b00) || fault_cause !== cause[i] || fault_pc !== fpc[i] ||
          out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bad_redirect %h: f=%b c=%b fpc=%h v=%b expected c=%b fpc=%h v=0",
                 tgt[i], fault, fault_cause, fault_pc, out_valid, cause[i], fpc[i]);
      end
    end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4C || imem_addr !== 32'h50) begin
      errors++;
      $display("FAIL last_word: v=%b pc=%h addr=%h expected 1/4c/50", out_valid, out_pc, imem_addr);
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    tick();
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0 || instr_count !== 32'd0 || fault !== 1'b0 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: v=%b addr=%h cnt=%0d f=%b pc=%h expected all 0",
               out_valid, imem_addr, instr_count, fault, out_pc);
    end
    rst = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL boot_ignores_redirect: v=%b addr=%h f=%b expected 0/0/0", out_valid, imem_addr, fault);
    end
    push_exp(32'h0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL post_reset_first: v=%b pc=%h expected 1/0", out_valid, out_pc);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (instr_count !== 32'd1) begin
      errors++; $display("FAIL post_reset_count: cnt=%0d expected 1", instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_handshake();
    test_bounds();
    test_bad_redirect();
    test_reset_midstream();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
